// File: rtl/polar_pkg.sv
// Shared polar-code definitions: encoder FSM states, LLR mapping and log2 helper.
package polar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DONE = 2'd2
  } enc_state_t;

  // Ideal saturated channel LLR for a hard bit; positive means bit 0.
  // The result is returned in the low 'width' bits of a 32-bit word.
  function automatic logic [31:0] llr_of_bit(input logic b, input int width, input int llr_mag);
    logic [31:0] mag_mask;
    logic [31:0] value;
    mag_mask = (32'd1 << width) - 32'd1;
    if (b) begin
      value = 32'(-llr_mag);
    end else begin
      value = 32'(llr_mag);
    end
    return value & mag_mask;
  endfunction

  // Integer log2 of a power of two (floor for other values).
  function automatic int log2_of(input int value);
    int result;
    result = 0;
    for (int v = value; v > 1; v = v / 2) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/polar_enc_stage.sv
// One butterfly stage of the natural-order polar transform:
// for every position whose stage bit is 0, xor in its partner 2**stage above.
module polar_enc_stage
  import polar_pkg::*;
#(
  parameter int N     = 1024,
  parameter int LOG2N = 10
) (
  input  logic [N-1:0]     vec_in,
  input  logic [LOG2N-1:0] stage,
  output logic [N-1:0]     vec_out
);

  logic [LOG2N-1:0] sel_s;

  // One-hot decode of the active stage, shared by every position
  always_comb begin
    sel_s = '0;
    for (int s = 0; s < LOG2N; s++) begin
      sel_s[s] = (stage == LOG2N'(s));
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pos
    logic [LOG2N-1:0] partner_s;

    // Upper position of a pair sees its partner; the lower one sees 0 and holds
    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
      if (((i >> s) % 2) == 0) begin : g_upper
        assign partner_s[s] = vec_in[i + (1 << s)];
      end else begin : g_lower
        assign partner_s[s] = 1'b0;
      end
    end

    assign vec_out[i] = vec_in[i] ^ (|(partner_s & sel_s));
  end

endmodule

// File: rtl/polar_encoder_seq.sv
// Sequential polar encoder: one butterfly stage per clock, emits the codeword
// and an ideal saturated LLR vector. Frames never overlap.
module polar_encoder_seq
  import polar_pkg::*;
#(
  parameter int             N           = 1024,
  parameter int             LOG2N       = 10,
  parameter int             WIDTH       = 6,
  parameter logic [N-1:0]   FROZEN_MASK = '0,
  parameter int             LLR_MAG     = 2**(WIDTH-1)-1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       u_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       x_out,
  output logic [N*WIDTH-1:0] llr_out,
  output logic               busy
);

  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);

  enc_state_t       state_q;
  logic [LOG2N-1:0] stage_q;
  logic [N-1:0]     vec_q;
  logic [N-1:0]     vec_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  polar_enc_stage #(
    .N     (N),
    .LOG2N (LOG2N)
  ) u_stage (
    .vec_in  (vec_q),
    .stage   (stage_q),
    .vec_out (vec_d)
  );

  // Frame FSM: load masked message, run LOG2N stages, hold result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      vec_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            vec_q      <= u_in & ~FROZEN_MASK;
            stage_q    <= '0;
            state_q    <= ENC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ENC: begin
          vec_q <= vec_d;
          if (stage_q == LAST_STAGE) begin
            state_q     <= DONE;
            stage_q     <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            stage_q <= stage_q + LOG2N'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          stage_q     <= '0;
          vec_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign x_out     = vec_q;

  for (genvar i = 0; i < N; i++) begin : g_llr
    logic [31:0] llr_word_s;
    assign llr_word_s                 = llr_of_bit(vec_q[i], WIDTH, LLR_MAG);
    assign llr_out[i*WIDTH +: WIDTH]  = llr_word_s[WIDTH-1:0];
  end

endmodule

// File: tb/tb_polar_encoder_seq.sv
// Randomized self-checking bench for polar_encoder_seq. Five builds share one
// stimulus bus: N=8 unmasked, N=8 with mask 0x17, N=16 masked, N=2, N=8 fully frozen.
module tb_polar_encoder_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] u_in;

  logic        rdy8, ov8, busy8;
  logic [7:0]  x8;
  logic [47:0] llr8;
  logic        rdym, ovm, busym;
  logic [7:0]  xm;
  logic [47:0] llrm;
  logic        rdys, ovs, busys;
  logic [15:0] xs;
  logic [95:0] llrs;
  logic        rdyt, ovt, busyt;
  logic [1:0]  xt;
  logic [11:0] llrt;
  logic        rdyf, ovf, busyf;
  logic [7:0]  xf;
  logic [47:0] llrf;

  localparam logic [15:0] MASK_M = 16'h0017;
  localparam logic [15:0] MASK_S = 16'h8C31;

  int n_vec;
  int n_err;

  polar_encoder_seq #(.N(8), .LOG2N(3), .WIDTH(6), .FROZEN_MASK(8'h00)) d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .u_in(u_in[7:0]),
    .out_valid(ov8), .out_ready(out_ready), .x_out(x8), .llr_out(llr8), .busy(busy8));

  polar_encoder_seq #(.N(8), .LOG2N(3), .WIDTH(6), .FROZEN_MASK(MASK_M[7:0])) dm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdym), .u_in(u_in[7:0]),
    .out_valid(ovm), .out_ready(out_ready), .x_out(xm), .llr_out(llrm), .busy(busym));

  polar_encoder_seq #(.N(16), .LOG2N(4), .WIDTH(6), .FROZEN_MASK(MASK_S)) ds (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdys), .u_in(u_in),
    .out_valid(ovs), .out_ready(out_ready), .x_out(xs), .llr_out(llrs), .busy(busys));

  polar_encoder_seq #(.N(2), .LOG2N(1), .WIDTH(6), .FROZEN_MASK(2'b00)) dt (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyt), .u_in(u_in[1:0]),
    .out_valid(ovt), .out_ready(out_ready), .x_out(xt), .llr_out(llrt), .busy(busyt));

  polar_encoder_seq #(.N(8), .LOG2N(3), .WIDTH(6), .FROZEN_MASK(8'hFF)) df (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyf), .u_in(u_in[7:0]),
    .out_valid(ovf), .out_ready(out_ready), .x_out(xf), .llr_out(llrf), .busy(busyf));

  always #5 clk = ~clk;

  // Generator-matrix view: x_j is the xor of every unfrozen u_i whose index covers j's bits
  function automatic logic [15:0] ref_encode(input logic [15:0] u, input logic [15:0] mask, input int n);
    logic [15:0] um;
    logic [15:0] x;
    um = u & ~mask;
    x  = '0;
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i < n; i++) begin
        if ((i & j) == j) x[j] = x[j] ^ um[i];
      end
    end
    return x;
  endfunction

  // +31 for bit 0, -31 (6'h21) for bit 1
  function automatic logic [127:0] ref_llr(input logic [15:0] x, input int n);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < n; j++) begin
      r[j*6 +: 6] = x[j] ? 6'h21 : 6'h1F;
    end
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [15:0] u);
    u_in     = u;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until every build shows out_valid, checking ENC status and latency
  task automatic wait_all();
    int k;
    int lat8;
    int lat16;
    int lat2;
    k = 0; lat8 = 0; lat16 = 0; lat2 = 0;
    check_val("busy_in_enc", 128'(busy8), 128'(1'b1));
    check_val("ready_in_enc", 128'(rdy8), 128'(1'b0));
    while (!(ov8 && ovm && ovs && ovt && ovf) && k < 20) begin
      step();
      k++;
      if (ov8 && lat8 == 0) lat8 = k;
      if (ovs && lat16 == 0) lat16 = k;
      if (ovt && lat2 == 0) lat2 = k;
    end
    check_val("latency_n8", 128'(lat8), 128'(3));
    check_val("latency_n16", 128'(lat16), 128'(4));
    check_val("latency_n2", 128'(lat2), 128'(1));
  endtask

  task automatic check_outputs(input logic [15:0] u);
    logic [15:0] e8, em, es, et;
    e8 = ref_encode(u, 16'h0000, 8);
    em = ref_encode(u, MASK_M, 8);
    es = ref_encode(u, MASK_S, 16);
    et = ref_encode(u, 16'h0000, 2);
    check_val("x_n8", 128'(x8), 128'(e8));
    check_val("llr_n8", 128'(llr8), ref_llr(e8, 8));
    check_val("x_n8_masked", 128'(xm), 128'(em));
    check_val("x_n16", 128'(xs), 128'(es));
    check_val("llr_n16", 128'(llrs), ref_llr(es, 16));
    check_val("x_n2", 128'(xt), 128'(et));
    check_val("llr_n2", 128'(llrt), ref_llr(et, 2));
    check_val("x_all_frozen", 128'(xf), 128'(0));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_val("valid_after_take", 128'(ov8), 128'(1'b0));
    check_val("ready_after_take", 128'(rdy8), 128'(1'b1));
  endtask

  task automatic run_frame(input logic [15:0] u);
    start_frame(u);
    wait_all();
    check_outputs(u);
    release_out();
  endtask

  initial begin
    logic [15:0] u_a;
    logic [15:0] u_b;
    logic [7:0]  x_hold;
    int          last;
    int          pulses;

    n_vec = 0; n_err = 0;
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; u_in = '0;
    step();
    step();
    // in_valid together with rst must be ignored
    in_valid = 1'b1; u_in = 16'hFFFF;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check_val("rst_in_ready", 128'(rdy8), 128'(1'b1));
    check_val("rst_out_valid", 128'(ov8), 128'(1'b0));
    check_val("rst_busy", 128'(busy8), 128'(1'b0));
    check_val("rst_x", 128'(x8), 128'(0));
    check_val("rst_llr", 128'(llr8), ref_llr(16'h0000, 8));
    step();
    check_val("rst_in_valid_ignored", 128'(busy8), 128'(1'b0));

    // Directed frames with hand-derived codewords
    start_frame(16'h0001); wait_all();
    check_val("single_u0", 128'(x8), 128'(8'h01));
    check_val("single_u0_llr", 128'(llr8), {80'h0, 48'h7DF7DF7DF7E1});
    check_outputs(16'h0001); release_out();
    start_frame(16'h0080); wait_all();
    check_val("top_u7", 128'(x8), 128'(8'hFF));
    check_outputs(16'h0080); release_out();
    start_frame(16'h00FF); wait_all();
    check_val("all_ones_n8", 128'(x8), 128'(8'h80));
    // masked u = 1110_1000 (u3,u5,u6,u7); superset xor gives 1001_0110
    check_val("mask17_golden", 128'(xm), 128'(8'h96));
    check_outputs(16'h00FF); release_out();

    // Backpressure: hold out_ready low, pulse in_valid in the window
    u_a = 16'h5A3C; u_b = 16'hC3E1;
    start_frame(u_a);
    wait_all();
    x_hold = ref_encode(u_a, 16'h0000, 8)[7:0];
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        u_in = u_b; in_valid = 1'b1;
      end
      step();
      in_valid = 1'b0;
      check_val("bp_valid_held", 128'(ov8), 128'(1'b1));
      check_val("bp_x_stable", 128'(x8), 128'(x_hold));
      check_val("bp_ready_low", 128'(rdy8), 128'(1'b0));
    end
    release_out();
    step();
    check_val("bp_pulse_dropped", 128'(busy8), 128'(1'b0));
    check_val("bp_no_output", 128'(ov8), 128'(1'b0));

    // Reset in the middle of ENC (stage 1), then a clean frame
    start_frame(16'hBEEF);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("abort_in_ready", 128'(rdy8), 128'(1'b1));
    check_val("abort_out_valid", 128'(ov8), 128'(1'b0));
    check_val("abort_busy", 128'(busy8), 128'(1'b0));
    check_val("abort_x_cleared", 128'(x8), 128'(0));
    run_frame(16'h1234);

    // Back-to-back with in_valid and out_ready tied high
    u_in = 16'h00A5; in_valid = 1'b1; out_ready = 1'b1;
    last = -1; pulses = 0;
    for (int c = 0; c < 32; c++) begin
      step();
      if (ov8) begin
        check_val("b2b_x", 128'(x8), 128'(ref_encode(16'h00A5, 16'h0000, 8)));
        if (last >= 0) check_val("b2b_period", 128'(c - last), 128'(5));
        last = c;
        pulses++;
      end
    end
    check_val("b2b_pulse_count", 128'(pulses), 128'(6));
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;

    // Random frames against the reference model
    for (int f = 0; f < 200; f++) begin
      run_frame(16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
